// File: rtl/rv32_mod_bus_arbiter.sv
// rv32_mod_bus_arbiter: shares one external memory port between instruction fetch
// (master 0) and load/store (master 1). A grant is held for a whole transaction,
// contention alternates between masters, and a stalled slave access is aborted
// with an error once TIMEOUT grant cycles have elapsed (TIMEOUT = 0 disables this).
// Latency: grant one cycle after a request is sampled; request and response paths
// are combinational through the granted master.
// Backpressure: a master holds mX_req until it sees mX_ack/mX_err; the slave stalls
// by withholding s_ack/s_err.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   mX_req/wr/be/addr/do               master X request fields (X = 0, 1)
//   mX_ack/err/di                      response to master X, zero unless granted
//   s_req/wr/be/addr/do                slave request, muxed from the granted master
//   s_ack/err/di                       slave response
//   grant                              one-hot registered grant (00 = idle)
//   timeout                            one-cycle pulse on a timeout abort
module rv32_mod_bus_arbiter #(
   parameter int TIMEOUT = 256,
   parameter bit PRIO_M1 = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_do,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_di,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_do,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_di,
   output logic        s_req,
   output logic        s_wr,
   output logic [3:0]  s_be,
   output logic [31:0] s_addr,
   output logic [31:0] s_do,
   input  logic        s_ack,
   input  logic        s_err,
   input  logic [31:0] s_di,
   output logic [1:0]  grant,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } state_t;

   // Counter value during the last allowed grant cycle; only meaningful when enabled.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
   localparam bit          TO_EN    = (TIMEOUT != 0);

   state_t      state;
   state_t      state_nx;
   logic [15:0] cnt;
   logic        g0;
   logic        g1;
   logic        done;

   assign g0    = (state == G0);
   assign g1    = (state == G1);
   assign grant = state;

   // A real slave response always beats a coincident timeout.
   assign timeout = TO_EN && (g0 || g1) && (cnt == CNT_LAST) && !s_ack && !s_err;
   assign done    = (g0 || g1) && (s_ack || s_err || timeout);

   // Next-state: the completing master never re-wins directly, which gives
   // round-robin under contention; a dropped request abandons the grant.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (m1_req && (PRIO_M1 || !m0_req)) state_nx = G1;
            else if (m0_req)                    state_nx = G0;
            else                                state_nx = IDLE;
         end
         G0: begin
            if (done)         state_nx = m1_req ? G1 : IDLE;
            else if (!m0_req) state_nx = IDLE;
            else              state_nx = G0;
         end
         G1: begin
            if (done)         state_nx = m0_req ? G0 : IDLE;
            else if (!m1_req) state_nx = IDLE;
            else              state_nx = G1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= 16'd0;
      end else begin
         state <= state_nx;
         // Restart the budget on every fresh grant, including G0<->G1 hand-over.
         if (state_nx != IDLE && state_nx != state) cnt <= 16'd0;
         else if (state != IDLE)                    cnt <= cnt + 16'd1;
      end
   end

   // Slave request mux; s_req is withheld in the abort cycle.
   always_comb begin
      s_req  = 1'b0;
      s_wr   = 1'b0;
      s_be   = 4'd0;
      s_addr = 32'd0;
      s_do   = 32'd0;
      if (g0) begin
         s_req  = m0_req && !timeout;
         s_wr   = m0_wr;
         s_be   = m0_be;
         s_addr = m0_addr;
         s_do   = m0_do;
      end else if (g1) begin
         s_req  = m1_req && !timeout;
         s_wr   = m1_wr;
         s_be   = m1_be;
         s_addr = m1_addr;
         s_do   = m1_do;
      end
   end

   // Responses are steered only to the granted master; idle-time responses vanish.
   assign m0_ack = s_ack && g0;
   assign m1_ack = s_ack && g1;
   assign m0_err = (s_err || timeout) && g0;
   assign m1_err = (s_err || timeout) && g1;
   assign m0_di  = g0 ? s_di : 32'd0;
   assign m1_di  = g1 ? s_di : 32'd0;

endmodule
